// File: rtl/multicycle_ctrl_if.sv
// Control/datapath bundle for the multicycle sequencer: instruction fields and status in, selects and strobes out.
// master = sequencer side, slave = datapath/memory side.
interface multicycle_ctrl_if #(
    parameter int OP_WIDTH       = 7,
    parameter int FUNCT3_WIDTH   = 3,
    parameter int ALU_CTRL_WIDTH = 3,
    parameter int IMM_SRC_WIDTH  = 2
);
    logic [OP_WIDTH-1:0]       op;
    logic [FUNCT3_WIDTH-1:0]   funct3;
    logic                      funct7_5;
    logic                      Zero;
    logic                      MemReady;
    logic                      PCWrite;
    logic                      AdrSrc;
    logic                      MemWrite;
    logic                      IRWrite;
    logic [1:0]                ResultSrc;
    logic [1:0]                ALUSrcA;
    logic [1:0]                ALUSrcB;
    logic [ALU_CTRL_WIDTH-1:0] ALUControl;
    logic [IMM_SRC_WIDTH-1:0]  ImmSrc;
    logic                      RegWrite;
    logic                      Retire;
    logic                      Trap;

    modport master (
        input  op, funct3, funct7_5, Zero, MemReady,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ALUControl, ImmSrc, RegWrite, Retire, Trap
    );

    modport slave (
        output op, funct3, funct7_5, Zero, MemReady,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ALUControl, ImmSrc, RegWrite, Retire, Trap
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// RV32I multicycle control FSM: lw 5 cycles, sw/R/I/jal 4, branch 3; MemReady=0 stalls FETCH/MEMREAD/MEMWRITE one cycle each.
// Optional MULTICYCLE_BNE_EN adds bne in BRANCH; otherwise any non-beq branch traps.
module multicycle_ctrl #(
    parameter int OP_WIDTH       = 7,
    parameter int FUNCT3_WIDTH   = 3,
    parameter int ALU_CTRL_WIDTH = 3,
    parameter int IMM_SRC_WIDTH  = 2
) (
    input  logic                CLK,
    input  logic                RST,
    multicycle_ctrl_if.master   bus
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BRANCH, S_JAL, S_TRAP
    } state_t;

    localparam logic [OP_WIDTH-1:0] OP_LOAD   = OP_WIDTH'(7'b0000011);
    localparam logic [OP_WIDTH-1:0] OP_STORE  = OP_WIDTH'(7'b0100011);
    localparam logic [OP_WIDTH-1:0] OP_RTYPE  = OP_WIDTH'(7'b0110011);
    localparam logic [OP_WIDTH-1:0] OP_ITYPE  = OP_WIDTH'(7'b0010011);
    localparam logic [OP_WIDTH-1:0] OP_BRANCH = OP_WIDTH'(7'b1100011);
    localparam logic [OP_WIDTH-1:0] OP_JAL    = OP_WIDTH'(7'b1101111);

    localparam logic [FUNCT3_WIDTH-1:0] F3_ADD = FUNCT3_WIDTH'(3'b000);
    localparam logic [FUNCT3_WIDTH-1:0] F3_BNE = FUNCT3_WIDTH'(3'b001);
    localparam logic [FUNCT3_WIDTH-1:0] F3_SLT = FUNCT3_WIDTH'(3'b010);
    localparam logic [FUNCT3_WIDTH-1:0] F3_OR  = FUNCT3_WIDTH'(3'b110);
    localparam logic [FUNCT3_WIDTH-1:0] F3_AND = FUNCT3_WIDTH'(3'b111);

    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_ADD = ALU_CTRL_WIDTH'(3'b000);
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SUB = ALU_CTRL_WIDTH'(3'b001);
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_AND = ALU_CTRL_WIDTH'(3'b010);
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_OR  = ALU_CTRL_WIDTH'(3'b011);
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLT = ALU_CTRL_WIDTH'(3'b101);

    state_t state_q, state_d;

    logic                      pc_write, adr_src, mem_write, ir_write, reg_write, retire, trap;
    logic [1:0]                result_src, alu_src_a, alu_src_b;
    logic [ALU_CTRL_WIDTH-1:0] alu_control, alu_funct;
    logic [IMM_SRC_WIDTH-1:0]  imm_src;
    logic                      funct_ok, branch_ok;

    always_ff @(posedge CLK) begin
        if (!RST) state_q <= S_FETCH;
        else      state_q <= state_d;
    end

    always_comb begin
        alu_funct = ALU_ADD;
        funct_ok  = 1'b1;
        case (bus.funct3)
            F3_ADD:  alu_funct = (bus.op[5] && bus.funct7_5) ? ALU_SUB : ALU_ADD;
            F3_SLT:  alu_funct = ALU_SLT;
            F3_OR:   alu_funct = ALU_OR;
            F3_AND:  alu_funct = ALU_AND;
            default: funct_ok  = 1'b0;
        endcase
    end

`ifdef MULTICYCLE_BNE_EN
    assign branch_ok = (bus.funct3 == F3_ADD) || (bus.funct3 == F3_BNE);
`else
    assign branch_ok = (bus.funct3 == F3_ADD);
`endif

    always_comb begin
        imm_src = IMM_SRC_WIDTH'(2'b00);
        case (bus.op)
            OP_STORE:  imm_src = IMM_SRC_WIDTH'(2'b01);
            OP_BRANCH: imm_src = IMM_SRC_WIDTH'(2'b10);
            OP_JAL:    imm_src = IMM_SRC_WIDTH'(2'b11);
            default:   imm_src = IMM_SRC_WIDTH'(2'b00);
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pc_write    = 1'b0;
        adr_src     = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        retire      = 1'b0;
        trap        = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_control = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (bus.MemReady) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                // Precompute OldPC + imm so BRANCH can load PC from ALUOut.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (bus.op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECUTER;
                    OP_ITYPE:          state_d = S_EXECUTEI;
                    OP_BRANCH:         state_d = branch_ok ? S_BRANCH : S_TRAP;
                    OP_JAL:            state_d = S_JAL;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                if (bus.MemReady) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (bus.MemReady) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXECUTER: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b00;
                alu_control = alu_funct;
                state_d     = funct_ok ? S_ALUWB : S_TRAP;
            end
            S_EXECUTEI: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = alu_funct;
                state_d     = funct_ok ? S_ALUWB : S_TRAP;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a   = 2'b10;
                alu_control = ALU_SUB;
                retire      = 1'b1;
                if (bus.funct3 == F3_ADD) pc_write = bus.Zero;
`ifdef MULTICYCLE_BNE_EN
                else if (bus.funct3 == F3_BNE) pc_write = ~bus.Zero;
`endif
                state_d = S_FETCH;
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
                state_d   = S_ALUWB;
            end
            S_TRAP: begin
                trap = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Reset gates every output combinationally so a stalled store drops MemWrite at once.
    assign bus.PCWrite    = RST & pc_write;
    assign bus.AdrSrc     = RST & adr_src;
    assign bus.MemWrite   = RST & mem_write;
    assign bus.IRWrite    = RST & ir_write;
    assign bus.RegWrite   = RST & reg_write;
    assign bus.Retire     = RST & retire;
    assign bus.Trap       = RST & trap;
    assign bus.ResultSrc  = RST ? result_src  : 2'b00;
    assign bus.ALUSrcA    = RST ? alu_src_a   : 2'b00;
    assign bus.ALUSrcB    = RST ? alu_src_b   : 2'b00;
    assign bus.ALUControl = RST ? alu_control : '0;
    assign bus.ImmSrc     = RST ? imm_src     : '0;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed cases plus randomized instructions scored per instruction.
module tb_multicycle_ctrl;
    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    multicycle_ctrl_if bus ();
    multicycle_ctrl dut (.CLK(CLK), .RST(RST), .bus(bus));

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                           IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111,
                           SYS = 7'b1110011;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] outs();
        return {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.ResultSrc,
                bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.ImmSrc,
                bus.RegWrite, bus.Retire, bus.Trap};
    endfunction

    function automatic int exp_alu(input logic [6:0] o, input logic [2:0] f3, input logic f75);
        case (f3)
            3'd0:    return (o[5] && f75) ? 1 : 0;
            3'd2:    return 5;
            3'd6:    return 3;
            3'd7:    return 2;
            default: return -1;
        endcase
    endfunction

    function automatic int exp_imm(input logic [6:0] o);
        if (o == SW) return 1;
        if (o == BR) return 2;
        if (o == JL) return 3;
        return 0;
    endfunction

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset(input int n);
        RST = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.MemReady = 1'(($urandom & 1));
            @(negedge CLK);
            chk("reset_outs_zero", 32'(outs()), 0);
            next_cycle();
        end
        RST = 1'b1;
        bus.MemReady = 1'b1;
    endtask

    // Runs one instruction from FETCH; k1 fetch stalls, k2 memory stalls.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f75,
                             input logic z, input int k1, input int k2, input string tag);
        bit is_lw, is_sw, mem, br, jal, exe, done, taken;
        int base, exp_cyc, n, n_ret, ret_cyc, n_mw, n_rw, n_pcw, n_irw, n_adr, n_trap;
        int aluc [40];
        int first_irpc, imm0, rs_at_rw;
        is_lw = (o == LW); is_sw = (o == SW); mem = is_lw || is_sw;
        br = (o == BR); jal = (o == JL); exe = (o == RT) || (o == IT);
        base = is_lw ? 5 : (br ? 3 : 4);
        exp_cyc = k1 + base + (mem ? k2 : 0);
        taken = br && ((f3 == 3'd0) ? z : !z);
        {n, n_ret, n_mw, n_rw, n_pcw, n_irw, n_adr, n_trap} = '0;
        ret_cyc = -1; rs_at_rw = -1; first_irpc = 0; imm0 = -1; done = 1'b0;
        bus.op = o; bus.funct3 = f3; bus.funct7_5 = f75; bus.Zero = z;
        while (!done && n < 40) begin
            if (n < k1)            bus.MemReady = 1'b0;
            else if (n == k1)      bus.MemReady = 1'b1;
            else if (n < k1 + 3)   bus.MemReady = 1'(($urandom & 1));
            else if (mem)          bus.MemReady = (n < k1 + 3 + k2) ? 1'b0 : 1'b1;
            else                   bus.MemReady = 1'(($urandom & 1));
            @(negedge CLK);
            aluc[n] = int'(bus.ALUControl);
            if (n == 0) begin
                first_irpc = int'({bus.IRWrite, bus.PCWrite});
                imm0 = int'(bus.ImmSrc);
            end
            n_mw  += int'(bus.MemWrite);
            n_pcw += int'(bus.PCWrite);
            n_irw += int'(bus.IRWrite);
            n_adr += int'(bus.AdrSrc);
            n_trap += int'(bus.Trap);
            if (bus.RegWrite) begin n_rw++; rs_at_rw = int'(bus.ResultSrc); end
            if (bus.Retire) begin n_ret++; ret_cyc = n; done = 1'b1; end
            n++;
            next_cycle();
        end
        chk({tag, "_cycles"}, 32'(n), 32'(exp_cyc));
        chk({tag, "_retire_count"}, 32'(n_ret), 1);
        chk({tag, "_retire_last"}, 32'(ret_cyc), 32'(exp_cyc - 1));
        chk({tag, "_first_irw_pcw"}, 32'(first_irpc), (k1 == 0) ? 3 : 0);
        chk({tag, "_immsrc"}, 32'(imm0), 32'(exp_imm(o)));
        chk({tag, "_memwrite_cycles"}, 32'(n_mw), is_sw ? 32'(k2 + 1) : 0);
        chk({tag, "_adrsrc_cycles"}, 32'(n_adr), mem ? 32'(k2 + 1) : 0);
        chk({tag, "_regwrite_cycles"}, 32'(n_rw), (is_lw || exe || jal) ? 1 : 0);
        chk({tag, "_pcwrite_cycles"}, 32'(n_pcw), 32'(1 + int'(jal) + int'(taken)));
        chk({tag, "_irwrite_cycles"}, 32'(n_irw), 1);
        chk({tag, "_trap_cycles"}, 32'(n_trap), 0);
        if (n_rw == 1)
            chk({tag, "_resultsrc_wb"}, 32'(rs_at_rw), is_lw ? 1 : 0);
        if ((exe || jal) && n == exp_cyc)
            chk({tag, "_aluctrl_exec"}, 32'(aluc[exp_cyc - 2]), jal ? 0 : 32'(exp_alu(o, f3, f75)));
        if (br && n == exp_cyc)
            chk({tag, "_aluctrl_branch"}, 32'(aluc[exp_cyc - 1]), 1);
    endtask

    // Illegal instruction: Trap from cycle index tcyc on, no strobes after fetch, cleared by reset.
    task automatic trap_test(input logic [6:0] o, input logic [2:0] f3, input int tcyc, input string tag);
        bus.op = o; bus.funct3 = f3; bus.funct7_5 = 1'b0; bus.Zero = 1'b0;
        for (int c = 0; c < tcyc + 4; c++) begin
            bus.MemReady = (c == 0) ? 1'b1 : 1'(($urandom & 1));
            @(negedge CLK);
            chk({tag, "_trap"}, 32'(bus.Trap), (c >= tcyc) ? 1 : 0);
            if (c >= 1)
                chk({tag, "_no_strobes"},
                    32'({bus.RegWrite, bus.MemWrite, bus.PCWrite, bus.Retire}), 0);
            next_cycle();
        end
        RST = 1'b0;
        @(negedge CLK);
        chk({tag, "_reset_clears"}, 32'(outs()), 0);
        next_cycle();
        RST = 1'b1;
        bus.MemReady = 1'b1;
    endtask

    initial begin
        logic [2:0] legal_f3 [4];
        int cls;
        logic [6:0] ro;
        logic [2:0] rf3;
        legal_f3 = '{3'd0, 3'd2, 3'd6, 3'd7};
        RST = 1'b0;
        bus.op = LW; bus.funct3 = 3'd0; bus.funct7_5 = 1'b0; bus.Zero = 1'b0; bus.MemReady = 1'b1;
        #1;
        do_reset(3);

        run_instr(LW, 3'd2, 1'b0, 1'b0, 0, 0, "lw");
        run_instr(SW, 3'd2, 1'b0, 1'b0, 0, 2, "sw_stall2");
        run_instr(RT, 3'd0, 1'b1, 1'b0, 0, 0, "r_sub");
        run_instr(IT, 3'd0, 1'b1, 1'b0, 1, 0, "i_addi");
        run_instr(BR, 3'd0, 1'b0, 1'b1, 0, 0, "beq_taken");
        run_instr(BR, 3'd0, 1'b0, 1'b0, 0, 0, "beq_not_taken");
        run_instr(JL, 3'd0, 1'b0, 1'b0, 2, 0, "jal");
`ifdef MULTICYCLE_BNE_EN
        run_instr(BR, 3'd1, 1'b0, 1'b0, 0, 0, "bne_taken");
`endif

        for (int i = 0; i < 40; i++) begin
            cls = int'($urandom_range(0, 5));
            rf3 = 3'($urandom);
            case (cls)
                0: ro = LW;
                1: ro = SW;
                2: begin ro = RT; rf3 = legal_f3[$urandom_range(0, 3)]; end
                3: begin ro = IT; rf3 = legal_f3[$urandom_range(0, 3)]; end
`ifdef MULTICYCLE_BNE_EN
                4: begin ro = BR; rf3 = 3'($urandom_range(0, 1)); end
`else
                4: begin ro = BR; rf3 = 3'd0; end
`endif
                default: ro = JL;
            endcase
            run_instr(ro, rf3, 1'(($urandom & 1)), 1'(($urandom & 1)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), "rand");
        end

        trap_test(SYS, 3'd0, 2, "trap_sys");
        trap_test(RT, 3'd1, 3, "trap_rfunct");
`ifndef MULTICYCLE_BNE_EN
        trap_test(BR, 3'd1, 2, "trap_bne");
`endif

        // Reset while a store is stalled in MEMWRITE.
        bus.op = SW; bus.funct3 = 3'd2; bus.funct7_5 = 1'b0; bus.Zero = 1'b0;
        for (int c = 0; c < 5; c++) begin
            bus.MemReady = (c == 0) ? 1'b1 : 1'b0;
            @(negedge CLK);
            if (c >= 3) chk("sw_stalled_memwrite", 32'(bus.MemWrite), 1);
            next_cycle();
        end
        RST = 1'b0;
        @(negedge CLK);
        chk("sw_reset_memwrite_drop", 32'(bus.MemWrite), 0);
        chk("sw_reset_outs_zero", 32'(outs()), 0);
        next_cycle();
        RST = 1'b1;
        bus.MemReady = 1'b1;
        run_instr(LW, 3'd2, 1'b0, 1'b0, 0, 1, "lw_after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control sequencer for the RV32I core. It replaces the single-cycle control path: one finite-state machine steps the shared ALU, register file and a unified instruction/data memory through fetch, decode, execute, memory and writeback cycles. It also handles a ready handshake from memory. The block sits beside the datapath and drives every mux select and write strobe. It decodes only the fields of the instruction register, which lives outside this block.

## Interface
Parameters:
- OP_WIDTH, 7, opcode width
- FUNCT3_WIDTH, 3, funct3 width
- ALU_CTRL_WIDTH, 3, ALUControl width
- IMM_SRC_WIDTH, 2, ImmSrc width

Ports:
- CLK  in  1  the single clock; all state updates on rising edge
- RST  in  1  synchronous, active-low reset
- op  in  OP_WIDTH  opcode field from the instruction register
- funct3  in  FUNCT3_WIDTH  funct3 field from the instruction register
- funct7_5  in  1  instruction bit 30
- Zero  in  1  ALU zero flag
- MemReady  in  1  memory has completed the current access this cycle
- PCWrite  out  1  PC register load enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register and OldPC load enable
- ResultSrc  out  2  result mux select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1
- ALUSrcB  out  2  ALU B select: 00 = rs2, 01 = ImmExt, 10 = constant 4
- ALUControl  out  ALU_CTRL_WIDTH  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt
- ImmSrc  out  IMM_SRC_WIDTH  immediate format: 00 I, 01 S, 10 B, 11 J
- RegWrite  out  1  register file write enable
- Retire  out  1  one-cycle pulse in the last cycle of each instruction
- Trap  out  1  sticky flag: illegal instruction seen

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH, JAL, TRAP.
- Any output not listed for a state is 0.
- FETCH:
  - Outputs: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10.
  - IRWrite and PCWrite are asserted only while MemReady=1.
  - Stays in FETCH while MemReady=0; otherwise next state is DECODE.
- DECODE:
  - Outputs: ALUSrcA=01, ALUSrcB=01, add (precomputes the branch target).
  - Next state by opcode: 0000011 or 0100011 → MEMADR; 0110011 → EXECUTER; 0010011 → EXECUTEI; 1100011 → BRANCH; 1101111 → JAL; any other opcode → TRAP.
- MEMADR:
  - Outputs: ALUSrcA=10, ALUSrcB=01, add.
  - Next state: MEMREAD if op[5]=0, else MEMWRITE.
- MEMREAD: AdrSrc=1. Waits for MemReady=1, then goes to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, Retire=1. Next state FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1. MemWrite is held until the cycle with MemReady=1; in that cycle Retire=1 and the next state is FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, funct decode. Next state ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, funct decode. Next state ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, Retire=1. Next state FETCH.
- BRANCH:
  - Outputs: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, Retire=1.
  - funct3=000: PCWrite=Zero.
  - Next state FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1. Next state ALUWB.
- TRAP: Trap=1 and all strobes are 0. The FSM stays in TRAP until reset.
- Funct decode:
  - funct3 000: sub if op[5]=1 and funct7_5=1, else add.
  - funct3 010: slt. 110: or. 111: and.
  - Any other funct3 in EXECUTER/EXECUTEI → next state TRAP instead of ALUWB.
- ImmSrc is decoded combinationally from op in every state: 0100011 → 01, 1100011 → 10, 1101111 → 11, else 00.

## Timing
- Reset: while RST=0, all outputs are 0 (combinational gating), the state register loads FETCH, and the Trap flag clears. The first cycle after release is FETCH.
- Reset mid-instruction, including a stalled MEMWRITE: MemWrite drops in the same cycle RST goes low, and no partial writeback occurs.
- Latency with MemReady=1 throughout: lw 5 cycles; sw, R-type, I-type and jal 4 cycles; branch 3 cycles.
- Each cycle with MemReady=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- MemReady is ignored in every other state.
- Retire is asserted exactly once per instruction. It is never asserted in TRAP.
- Trap rises in the first TRAP cycle and holds.
- All outputs are Moore outputs, except the MemReady-gated and Zero-gated strobes.

## Configuration
- MULTICYCLE_BNE_EN defined: BRANCH with funct3=001 sets PCWrite=~Zero.
- MULTICYCLE_BNE_EN undefined: a branch with any funct3 other than 000 goes DECODE → TRAP.

## Test plan
- Reset held 3 cycles, then released with MemReady=1 → all outputs 0 during reset; FETCH shows IRWrite=1 and PCWrite=1 in the first cycle after release.
- lw (op=0000011), MemReady=1 → states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 with ResultSrc=01 in cycle 5; Retire only in cycle 5.
- sw with MemReady low for 2 cycles in MEMWRITE → MemWrite=1 for 3 cycles; Retire in the 3rd; total 6 cycles.
- R-type sub (funct3=000, funct7_5=1) → ALUControl=001 in EXECUTER; beq with Zero=1 → PCWrite=1 in BRANCH; beq with Zero=0 → PCWrite=0.
- op=1110011 → Trap=1 from cycle 3; no RegWrite, MemWrite or PCWrite until RST=0.
- bne (funct3=001), Zero=0: with MULTICYCLE_BNE_EN → PCWrite=1 in BRANCH; without it → Trap=1.
